// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types: widths, access-size codes, arbiter states.
// Imported by the arbiter, its port interface and the bench.
package dmem_arbiter_pkg;

   localparam int DMEM_XLEN = 32;
   localparam int ADDR_SIZE = 32;

   localparam logic [1:0] SZ_ILL = 2'b00;
   localparam logic [1:0] SZ_B   = 2'b01;
   localparam logic [1:0] SZ_H   = 2'b10;
   localparam logic [1:0] SZ_W   = 2'b11;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   function automatic logic sz_ill(input logic [1:0] s);
      return s == SZ_ILL;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side port of the data-memory arbiter.
// master = requester (core LSU / aux master), slave = arbiter.
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
   #(parameter int XLEN = DMEM_XLEN) ();

   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [1:0]      size;
   logic            lu;
   logic            lock;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;
   logic            err;

   modport master (
      output req, we, addr, wdata,
      output size, lu, lock,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      input  size, lu, lock,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/dmem_rsp_reg.sv
// Per-port response register: rvalid/err pulses and held load data.
// Illegal-size loads return zero instead of the memory word.
module dmem_rsp_reg #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            take,
   input  logic            load,
   input  logic            ill,
   input  logic [XLEN-1:0] rd,
   output logic            rvalid,
   output logic            err,
   output logic [XLEN-1:0] rdata
);

   always_ff @(posedge clk) begin
      if (reset) begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= take && load;
         err    <= take && ill;
         if (take && load)
            rdata <= ill ? '0 : rd;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: port 0 priority, port-1 aging, lockable ownership.
// Grants are combinational; load data comes back one cycle later.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int XLEN         = DMEM_XLEN,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   dmem_arbiter_if.slave     p0,
   dmem_arbiter_if.slave     p1,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_a,
   output logic [XLEN-1:0]   mem_wd,
   output logic [1:0]        mem_lwhb,
   output logic [1:0]        mem_swhb,
   output logic              mem_lu,
   input  logic [XLEN-1:0]   mem_rd
);

   localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

   arb_state_t state;
   logic [7:0] age;
   logic       g0;
   logic       g1;
   logic       starve;

   assign starve = p1.req && (age == LIM);

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            g1 = starve || (!p0.req && p1.req);
            g0 = p0.req && !starve;
         end
         ARB_OWN0: g0 = p0.req;
         ARB_OWN1: g1 = p1.req;
         default: ;
      endcase
      // no access may reach dmem while reset is asserted
      if (reset) begin
         g0 = 1'b0;
         g1 = 1'b0;
      end
   end

   assign p0.gnt = g0;
   assign p1.gnt = g1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_IDLE;
         age   <= '0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (g0 && p0.lock)
                  state <= ARB_OWN0;
               else if (g1 && p1.lock)
                  state <= ARB_OWN1;
            end
            ARB_OWN0: if (!p0.lock) state <= ARB_IDLE;
            ARB_OWN1: if (!p1.lock) state <= ARB_IDLE;
            default:  state <= ARB_IDLE;
         endcase
         if (!p1.req || g1)
            age <= '0;
         else if (age < LIM)
            age <= age + 8'd1;
      end
   end

   assign mem_a    = g1 ? p1.addr  : p0.addr;
   assign mem_wd   = g1 ? p1.wdata : p0.wdata;
   assign mem_lwhb = g1 ? p1.size  : p0.size;
   assign mem_swhb = mem_lwhb;
   assign mem_lu   = g1 ? p1.lu    : p0.lu;

   always_comb begin
      mem_we = 1'b0;
      if (g0)
         mem_we = p0.we && !sz_ill(p0.size);
      else if (g1)
         mem_we = p1.we && !sz_ill(p1.size);
   end

   logic ld0, ld1, ill0, ill1;
   assign ld0  = !p0.we;
   assign ld1  = !p1.we;
   assign ill0 = sz_ill(p0.size);
   assign ill1 = sz_ill(p1.size);

   dmem_rsp_reg #(.XLEN(XLEN)) u_rsp0 (
      .clk    (clk),
      .reset  (reset),
      .take   (g0),
      .load   (ld0),
      .ill    (ill0),
      .rd     (mem_rd),
      .rvalid (p0.rvalid),
      .err    (p0.err),
      .rdata  (p0.rdata)
   );

   dmem_rsp_reg #(.XLEN(XLEN)) u_rsp1 (
      .clk    (clk),
      .reset  (reset),
      .take   (g1),
      .load   (ld1),
      .ill    (ill1),
      .rd     (mem_rd),
      .rvalid (p1.rvalid),
      .err    (p1.err),
      .rdata  (p1.rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-wide dmem model plus per-port scoreboard.
// Directed vectors; responses are checked by an independent monitor.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.XLEN(32)) p0 ();
   dmem_arbiter_if #(.XLEN(32)) p1 ();

   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [1:0]  mem_lwhb;
   logic [1:0]  mem_swhb;
   logic        mem_lu;
   logic [31:0] mem_rd;

   dmem_arbiter #(.XLEN(32), .STARVE_LIMIT(3)) dut (
      .clk      (clk),
      .reset    (reset),
      .p0       (p0),
      .p1       (p1),
      .mem_we   (mem_we),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
      .mem_lwhb (mem_lwhb),
      .mem_swhb (mem_swhb),
      .mem_lu   (mem_lu),
      .mem_rd   (mem_rd)
   );

   bit [7:0] mem [256];
   logic [7:0] ma;
   assign ma = mem_a[7:0];

   always_comb begin
      mem_rd = '0;
      case (mem_lwhb)
         SZ_B: mem_rd = {{24{~mem_lu & mem[ma][7]}}, mem[ma]};
         SZ_H: mem_rd = {{16{~mem_lu & mem[ma+8'd1][7]}},
                         mem[ma+8'd1], mem[ma]};
         SZ_W: mem_rd = {mem[ma+8'd3], mem[ma+8'd2],
                         mem[ma+8'd1], mem[ma]};
         default: mem_rd = '0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_we) begin
         case (mem_swhb)
            SZ_B: mem[ma] <= mem_wd[7:0];
            SZ_H: begin
               mem[ma]       <= mem_wd[7:0];
               mem[ma+8'd1]  <= mem_wd[15:8];
            end
            SZ_W: begin
               mem[ma]       <= mem_wd[7:0];
               mem[ma+8'd1]  <= mem_wd[15:8];
               mem[ma+8'd2]  <= mem_wd[23:16];
               mem[ma+8'd3]  <= mem_wd[31:24];
            end
            default: ;
         endcase
      end
   end

   typedef struct {
      logic        load;
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t q0 [$];
   rsp_t q1 [$];
   int checks = 0;
   int fails  = 0;

   task automatic chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endtask

   task automatic expect_rsp(input int p, input logic ld,
                             input logic er, input logic [31:0] d);
      rsp_t r;
      r.load = ld;
      r.err  = er;
      r.data = d;
      if (p == 0) q0.push_back(r);
      else        q1.push_back(r);
   endtask

   task automatic pop_chk(input int p, input logic rv,
                          input logic er, input logic [31:0] rd);
      rsp_t r;
      if ((p == 0 && q0.size() == 0) ||
          (p == 1 && q1.size() == 0)) begin
         checks++;
         fails++;
         $display("FAIL unexpected_rsp%0d rvalid=%b err=%b",
                  p, rv, er);
      end else begin
         if (p == 0) r = q0.pop_front();
         else        r = q1.pop_front();
         chk($sformatf("rvalid%0d", p), 32'(rv), 32'(r.load));
         chk($sformatf("err%0d", p), 32'(er), 32'(r.err));
         if (r.load)
            chk($sformatf("rdata%0d", p), rd, r.data);
      end
   endtask

   always @(negedge clk) begin
      if (p0.rvalid === 1'b1 || p0.err === 1'b1)
         pop_chk(0, p0.rvalid, p0.err, p0.rdata);
      if (p1.rvalid === 1'b1 || p1.err === 1'b1)
         pop_chk(1, p1.rvalid, p1.err, p1.rdata);
   end

   task automatic rq(input int p, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic u,
                     input logic k);
      if (p == 0) begin
         p0.req = r; p0.we = w; p0.addr = a; p0.wdata = d;
         p0.size = s; p0.lu = u; p0.lock = k;
      end else begin
         p1.req = r; p1.we = w; p1.addr = a; p1.wdata = d;
         p1.size = s; p1.lu = u; p1.lock = k;
      end
   endtask

   task automatic idle(input int p);
      rq(p, 0, 0, 32'h0, 32'h0, SZ_W, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic gnts(input string n, input logic e0,
                       input logic e1);
      chk({n, "_gnt0"}, 32'(p0.gnt), 32'(e0));
      chk({n, "_gnt1"}, 32'(p1.gnt), 32'(e1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   logic [31:0] ext_a [5] = '{32'h21, 32'h21, 32'h20, 32'h20, 32'h22};
   logic [1:0]  ext_s [5] = '{SZ_B, SZ_B, SZ_H, SZ_H, SZ_H};
   logic        ext_u [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] ext_e [5] = '{32'hFFFFFF80, 32'h00000080,
                              32'hFFFF807F, 32'h0000807F,
                              32'h00002211};

   initial begin
      idle(0);
      idle(1);
      step();
      step();
      // store request while reset held: must not grant or write
      rq(0, 1, 1, 32'h10, 32'h55, SZ_W, 0, 0);
      @(negedge clk);
      gnts("rst", 0, 0);
      chk("rst_mem_we", 32'(mem_we), 32'h0);
      chk("rst_rvalid0", 32'(p0.rvalid), 32'h0);
      chk("rst_err1", 32'(p1.err), 32'h0);
      chk("rst_rdata0", p0.rdata, 32'h0);
      step();
      reset = 1'b0;
      idle(0);
      @(negedge clk);
      gnts("idle", 0, 0);

      // simultaneous requests
      step();
      rq(0, 1, 1, 32'h10, 32'hDEADBEEF, SZ_W, 0, 0);
      rq(1, 1, 0, 32'h10, 32'h0, SZ_W, 0, 0);
      @(negedge clk);
      gnts("sim_c0", 1, 0);
      chk("sim_c0_we", 32'(mem_we), 32'h1);
      chk("sim_c0_wd", mem_wd, 32'hDEADBEEF);
      step();
      idle(0);
      expect_rsp(1, 1, 0, 32'hDEADBEEF);
      @(negedge clk);
      gnts("sim_c1", 0, 1);
      chk("sim_c1_we", 32'(mem_we), 32'h0);
      step();
      idle(1);
      @(negedge clk);
      gnts("sim_c2", 0, 0);

      // starvation with limit 3
      for (int i = 0; i < 3; i++) begin
         step();
         rq(0, 1, 0, 32'h10, 32'h0, SZ_W, 0, 0);
         rq(1, 1, 0, 32'h10, 32'h0, SZ_H, 1, 0);
         expect_rsp(0, 1, 0, 32'hDEADBEEF);
         @(negedge clk);
         gnts($sformatf("starve_c%0d", i), 1, 0);
      end
      step();
      expect_rsp(1, 1, 0, 32'h0000BEEF);
      @(negedge clk);
      gnts("starve_c3", 0, 1);
      chk("starve_lwhb", 32'(mem_lwhb), 32'(SZ_H));
      step();
      expect_rsp(0, 1, 0, 32'hDEADBEEF);
      @(negedge clk);
      gnts("starve_c4", 1, 0);
      step();
      idle(0);
      idle(1);
      @(negedge clk);

      // port 1 locked byte-store burst
      step();
      rq(1, 1, 1, 32'h21, 32'h80, SZ_B, 0, 1);
      @(negedge clk);
      gnts("lock_c0", 0, 1);
      step();
      rq(0, 1, 0, 32'h20, 32'h0, SZ_W, 0, 0);
      rq(1, 1, 1, 32'h22, 32'h11, SZ_B, 0, 1);
      @(negedge clk);
      gnts("lock_c1", 0, 1);
      step();
      rq(1, 1, 1, 32'h23, 32'h22, SZ_B, 0, 1);
      @(negedge clk);
      gnts("lock_c2", 0, 1);
      step();
      rq(1, 1, 1, 32'h20, 32'h7F, SZ_B, 0, 0);
      @(negedge clk);
      gnts("lock_c3", 0, 1);
      chk("lock_swhb", 32'(mem_swhb), 32'(SZ_B));
      step();
      idle(1);
      expect_rsp(0, 1, 0, 32'h2211807F);
      @(negedge clk);
      gnts("lock_c4", 1, 0);

      // sign / zero extension, back-to-back on port 0
      for (int i = 0; i < 5; i++) begin
         step();
         rq(0, 1, 0, ext_a[i], 32'h0, ext_s[i], ext_u[i], 0);
         expect_rsp(0, 1, 0, ext_e[i]);
         @(negedge clk);
         chk($sformatf("ext%0d_gnt0", i), 32'(p0.gnt), 32'h1);
      end
      step();
      idle(0);
      @(negedge clk);

      // illegal size
      step();
      rq(0, 1, 1, 32'h30, 32'h12345678, SZ_W, 0, 1);
      @(negedge clk);
      chk("ill_st_we", 32'(mem_we), 32'h1);
      step();
      rq(0, 1, 1, 32'h30, 32'hAAAAAAAA, SZ_ILL, 0, 0);
      expect_rsp(0, 0, 1, 32'h0);
      @(negedge clk);
      gnts("ill_c0", 1, 0);
      chk("ill_we", 32'(mem_we), 32'h0);
      step();
      rq(0, 1, 0, 32'h30, 32'h0, SZ_W, 0, 0);
      expect_rsp(0, 1, 0, 32'h12345678);
      @(negedge clk);
      gnts("ill_rd", 1, 0);
      step();
      idle(0);
      rq(1, 1, 0, 32'h30, 32'h0, SZ_ILL, 0, 0);
      expect_rsp(1, 1, 1, 32'h0);
      @(negedge clk);
      gnts("ill_ld1", 0, 1);
      step();
      idle(1);
      @(negedge clk);

      // reset while port 0 owns the memory
      step();
      rq(0, 1, 0, 32'h30, 32'h0, SZ_W, 0, 1);
      expect_rsp(0, 1, 0, 32'h12345678);
      @(negedge clk);
      gnts("own_c0", 1, 0);
      step();
      rq(1, 1, 0, 32'h10, 32'h0, SZ_W, 0, 0);
      expect_rsp(0, 1, 0, 32'h12345678);
      @(negedge clk);
      gnts("own_c1", 1, 0);
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_we", 32'(mem_we), 32'h0);
      step();
      reset = 1'b0;
      idle(0);
      expect_rsp(1, 1, 0, 32'hDEADBEEF);
      @(negedge clk);
      gnts("post_rst", 0, 1);
      chk("post_rst_rvalid0", 32'(p0.rvalid), 32'h0);
      chk("post_rst_rdata0", p0.rdata, 32'h0);
      step();
      idle(1);
      step();
      step();
      @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data memory (`dmem`) between the core's load/store port (port 0) and an auxiliary master (port 1: program loader / debug / DMA). It sits between the requesters and `dmem`. Each cycle it picks one request, drives `dmem`'s write-enable, address, write-data and size/extension controls, and returns registered read data to the winner. Port 0 has fixed priority. An aging counter bounds port-1 starvation, and a lock input lets a winner hold the memory for multi-access sequences.

## Interface
Parameters:
- `XLEN`, default 32: data and address width.
- `STARVE_LIMIT`, default 8: consecutive lost cycles after which port 1 overrides port 0 priority. Legal range 1..255.

Ports (n = 0, 1 for each per-port signal):
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `reqn` input, 1 bit: access request. Held with stable fields until granted.
- `wen` input, 1 bit: 1 = store, 0 = load.
- `addrn` input, XLEN bits: byte address.
- `wdatan` input, XLEN bits: store data, LSB-aligned.
- `sizen` input, 2 bits: 01 = byte, 10 = half, 11 = word, 00 = illegal.
- `lun` input, 1 bit: load zero-extend.
- `lockn` input, 1 bit: keep ownership after this access.
- `gntn` output, 1 bit: combinational grant. The access is performed in the cycle where `reqn && gntn` is true.
- `rvalidn` output, 1 bit: read data valid, one cycle after a granted load.
- `rdatan` output, XLEN bits: registered load data.
- `errn` output, 1 bit: one-cycle pulse one cycle after a granted illegal-size access.
- `mem_we` output, 1 bit: to `dmem.we`.
- `mem_a` output, XLEN bits: to `dmem.a`.
- `mem_wd` output, XLEN bits: to `dmem.wd`.
- `mem_lwhb` output, 2 bits: to `dmem.lwhb`.
- `mem_swhb` output, 2 bits: to `dmem.swhb`.
- `mem_lu` output, 1 bit: to `dmem.lu`.
- `mem_rd` input, XLEN bits: from `dmem.rd`, combinational read.

## Operation
- States: IDLE (no owner), OWN0, OWN1 (locked owner).
- In IDLE, arbitration order:
  - `age == STARVE_LIMIT` and `req1`: grant port 1.
  - otherwise `req0`: grant port 0.
  - otherwise `req1`: grant port 1.
- In OWNn, only port n can be granted. The other port's `gnt` is 0 even if port n is idle.
- Ownership transitions:
  - A granted access with `lockn` = 1 moves the FSM to OWNn, or keeps it there.
  - While in OWNn, `lockn` = 0 returns the FSM to IDLE, regardless of `reqn`.
  - A granted access with `lockn` = 0 leaves or keeps the FSM in IDLE.
- At most one `gnt` is high in any cycle. `gnt` depends on state, `age` and `req` only, never on `addr` or `data`.
- Mux: the `mem_*` outputs carry the granted port's fields.
  - `mem_we` = `wen && gnt && size != 00`.
  - `mem_swhb` = `mem_lwhb` = granted size.
  - With no grant: `mem_we` = 0, and the other `mem_*` outputs carry port 0's fields.
- Granted load: `mem_rd` is captured into `rdatan` at the edge ending the grant cycle. `rvalidn` is 1 for exactly the next cycle. `rdatan` holds its value until the next load completes on that port.
- Granted store: no `rvalid`. The write lands in `dmem` at the edge ending the grant cycle.
- Illegal size (00): the request is granted and consumed.
  - `mem_we` is forced 0.
  - The next cycle has `errn` = 1, and `rvalidn` = 1 with `rdatan` = 0 if it was a load.
- Aging counter `age`, width 8:
  - Increments, saturating at `STARVE_LIMIT`, in each cycle with `req1 && !gnt1`.
  - Clears on a port-1 grant or when `req1` = 0.
  - Does not increment while in OWN0 only if `STARVE_LIMIT` would be exceeded (saturation holds).
- Simultaneous events:
  - Port 0 unlocks and port 1 requests in the same cycle: the FSM goes to IDLE, and port 1 competes from the next cycle.
  - A read-data return and a new grant in the same cycle are independent and both proceed.
- Alignment: address alignment is not checked. The arbiter passes addresses through unmodified.

## Timing
- Reset values: FSM = IDLE, `age` = 0. `gntn`, `rvalidn`, `errn` = 0 and `rdatan` = 0 from the first cycle after `reset` is sampled high. `mem_we` = 0 while `reset` is high.
- Reset mid-operation: pending `rvalid`/`err` for an access granted in the reset cycle are dropped, and any held lock is released.
- Grant latency: 0 cycles (combinational). Load data latency: 1 cycle. Throughput: one access per cycle, back-to-back on the same port.
- Worst-case port-1 wait with no locks: `STARVE_LIMIT`+1 cycles. With a port-0 lock, the wait is unbounded, which is by design.

## Structure
- Shared package/defines (alongside the existing `XLEN`/`ADDR_SIZE` defines): the size encodings `SZ_B`=01, `SZ_H`=10, `SZ_W`=11, `SZ_ILL`=00, and the FSM state encodings ARB_IDLE/ARB_OWN0/ARB_OWN1.
- One sub-module, `dmem_rsp_reg`, instantiated once per port: the per-port response register holding `rvalid`, `err` and `rdata`.

## Test plan
- Simultaneous requests: `req0` = `req1` = 1, port 0 word store 0xDEADBEEF to 0x10, port 1 load 0x10 → cycle 0 `gnt0` = 1 only; cycle 1 `gnt1`; cycle 2 `rvalid1` = 1 with `rdata1` = 0xDEADBEEF.
- Starvation: `STARVE_LIMIT` = 3, `req0` held 1 continuously, `req1` = 1 → `gnt1` first asserts in the 4th cycle, then `age` = 0 and port 0 regains priority.
- Lock: port 1 issues 3 byte stores with `lock1` = 1, then one with `lock1` = 0, while `req0` = 1 → `gnt0` = 0 for all 4 cycles and asserts in the 5th.
- Sign/zero extension: byte 0x80 at 0x21; load byte `lu` = 0 → 0xFFFFFF80; `lu` = 1 → 0x00000080; half load at 0x20 with `lu` = 0 → sign-extended per stored bytes.
- Illegal size: port 0 store with size 00 to 0x30 holding 0x12345678 → `mem_we` stays 0, `err0` pulses 1 cycle, and a later word read of 0x30 returns 0x12345678.
- Reset: assert `reset` in the cycle port 0 is granted a load while in OWN0 → next cycle `rvalid0` = 0, state IDLE, `age` = 0, and `req1` is granted immediately.
